// File: rtl/ce_gen_pkg.sv
// ce_gen_pkg: shared defaults and factor/phase helpers for the multi-channel
// clock-enable generator. The helpers work on 32-bit values, so W must not
// exceed 32.
package ce_gen_pkg;

  localparam int CE_GEN_CH_DEF = 4;
  localparam int CE_GEN_W_DEF  = 16;

  // Factors 0 and 1 both mean divide-by-1.
  function automatic logic [31:0] eff_factor(input logic [31:0] f);
    if (f == 32'd0) begin
      return 32'd1;
    end else begin
      return f;
    end
  endfunction

  // A start phase can never place the counter beyond the last count of the
  // period (fe - 1). fe is always at least 1.
  function automatic logic [31:0] clamp_phase(input logic [31:0] ph,
                                              input logic [31:0] fe);
    if (ph > (fe - 32'd1)) begin
      return fe - 32'd1;
    end else begin
      return ph;
    end
  endfunction

endpackage

// File: rtl/ce_gen_multi_if.sv
// ce_gen_multi_if: control/status bundle of ce_gen_multi.
// The phase bus exists only when CE_GEN_MULTI_PHASE_EN is defined.
interface ce_gen_multi_if #(
  parameter int CH = ce_gen_pkg::CE_GEN_CH_DEF,
  parameter int W  = ce_gen_pkg::CE_GEN_W_DEF
);
  logic [CH-1:0]   en;
  logic [CH*W-1:0] factor;
  logic [CH-1:0]   load;
  logic            sync;
`ifdef CE_GEN_MULTI_PHASE_EN
  logic [CH*W-1:0] phase;
`endif
  logic [CH-1:0]   ce;
  logic [CH-1:0]   pending;

`ifdef CE_GEN_MULTI_PHASE_EN
  modport master (output en, factor, load, sync, phase, input ce, pending);
  modport slave  (input en, factor, load, sync, phase, output ce, pending);
`else
  modport master (output en, factor, load, sync, input ce, pending);
  modport slave  (input en, factor, load, sync, output ce, pending);
`endif
endinterface

// File: rtl/ce_gen_channel.sv
// ce_gen_channel: one clock-enable channel. Holds the period counter, the
// active and shadow factors, the pending flag and the registered ce pulse.
// Factor changes requested while running are parked in the shadow register
// and applied only at a period boundary (wrap), on sync, or while disabled.
// With CE_GEN_MULTI_PHASE_EN defined, sync preloads the counter from phase_i.
module ce_gen_channel
  import ce_gen_pkg::*;
#(
  parameter int W            = CE_GEN_W_DEF,
  parameter int RESET_FACTOR = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en_i,
  input  logic         sync_i,
  input  logic         load_i,
  input  logic [W-1:0] factor_i,
`ifdef CE_GEN_MULTI_PHASE_EN
  input  logic [W-1:0] phase_i,
`endif
  output logic         ce_o,
  output logic         pending_o
);

  logic [W-1:0] cnt_q, cnt_d;
  logic [W-1:0] fa_q, fa_d;
  logic [W-1:0] fs_q, fs_d;
  logic         pending_q, pending_d;
  logic         ce_q, ce_d;

  logic [W-1:0] fe_s;
  logic [W-1:0] fa_new_s;
  logic [W-1:0] sync_cnt_s;
  logic         wrap_s;

  // Next-state decode: disable, sync, wrap, count -- in that priority.
  always_comb begin
    cnt_d      = cnt_q;
    fa_d       = fa_q;
    fs_d       = fs_q;
    pending_d  = pending_q;
    ce_d       = 1'b0;

    fe_s   = W'(eff_factor(32'(fa_q)));
    wrap_s = (cnt_q == (fe_s - W'(32'd1)));

    // Factor that becomes active at any boundary: a fresh load bypasses the
    // shadow register, otherwise a pending shadow value is promoted.
    if (load_i) begin
      fa_new_s = factor_i;
    end else if (pending_q) begin
      fa_new_s = fs_q;
    end else begin
      fa_new_s = fa_q;
    end

`ifdef CE_GEN_MULTI_PHASE_EN
    sync_cnt_s = W'(clamp_phase(32'(phase_i), eff_factor(32'(fa_new_s))));
`else
    sync_cnt_s = {W{1'b0}};
`endif

    if (!en_i) begin
      cnt_d     = {W{1'b0}};
      fa_d      = fa_new_s;
      pending_d = 1'b0;
    end else if (sync_i) begin
      cnt_d     = sync_cnt_s;
      fa_d      = fa_new_s;
      pending_d = 1'b0;
    end else if (wrap_s) begin
      cnt_d     = {W{1'b0}};
      ce_d      = 1'b1;
      fa_d      = fa_new_s;
      pending_d = 1'b0;
    end else begin
      cnt_d = cnt_q + W'(32'd1);
      if (load_i) begin
        fs_d      = factor_i;
        pending_d = 1'b1;
      end else begin
        fs_d      = fs_q;
        pending_d = pending_q;
      end
    end
  end

  // Channel state registers with asynchronous reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q     <= {W{1'b0}};
      fa_q      <= W'(RESET_FACTOR);
      fs_q      <= {W{1'b0}};
      pending_q <= 1'b0;
      ce_q      <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      fa_q      <= fa_d;
      fs_q      <= fs_d;
      pending_q <= pending_d;
      ce_q      <= ce_d;
    end
  end

  assign ce_o      = ce_q;
  assign pending_o = pending_q;

endmodule

// File: rtl/ce_gen_multi.sv
// ce_gen_multi: CH independent clock-enable generators with shadow-buffered,
// glitch-free factor updates and a common sync restart. The top level only
// slices the buses and fans out sync; all state lives in ce_gen_channel.
// Optional feature macro: CE_GEN_MULTI_PHASE_EN (per-channel sync phase).
module ce_gen_multi
  import ce_gen_pkg::*;
#(
  parameter int CH           = CE_GEN_CH_DEF,
  parameter int W            = CE_GEN_W_DEF,
  parameter int RESET_FACTOR = 1
) (
  input  logic           clk,
  input  logic           rst,
  ce_gen_multi_if.slave  bus
);

  logic [CH-1:0] ce_s;
  logic [CH-1:0] pending_s;

  for (genvar i = 0; i < CH; i++) begin : g_ch
    ce_gen_channel #(
      .W            (W),
      .RESET_FACTOR (RESET_FACTOR)
    ) u_ch (
      .clk       (clk),
      .rst       (rst),
      .en_i      (bus.en[i]),
      .sync_i    (bus.sync),
      .load_i    (bus.load[i]),
      .factor_i  (bus.factor[i*W +: W]),
`ifdef CE_GEN_MULTI_PHASE_EN
      .phase_i   (bus.phase[i*W +: W]),
`endif
      .ce_o      (ce_s[i]),
      .pending_o (pending_s[i])
    );
  end

  assign bus.ce      = ce_s;
  assign bus.pending = pending_s;

endmodule

// File: tb/tb_ce_gen_multi.sv
// tb_ce_gen_multi: directed scenarios with literal expectations plus a long
// randomized run, all checked against a behavioural per-channel model.
module tb_ce_gen_multi;

  localparam int CH = 4;
  localparam int W  = 16;

  logic clk;
  logic rst;
  int   total = 0;
  int   bad   = 0;
  bit   run_cmp = 1'b0;

  ce_gen_multi_if #(.CH(CH), .W(W)) bus ();

  ce_gen_multi #(.CH(CH), .W(W), .RESET_FACTOR(1)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural model: period position, active/shadow factor, pending, ce.
  int            m_cnt [CH];
  int            m_fa  [CH];
  int            m_fs  [CH];
  logic [CH-1:0] m_pend;
  logic [CH-1:0] m_ce;

  // Model update on each active edge (or asynchronously on reset).
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < CH; i++) begin
        m_cnt[i] = 0; m_fa[i] = 1; m_fs[i] = 0;
      end
      m_pend = '0;
      m_ce   = '0;
    end else begin
      for (int i = 0; i < CH; i++) begin
        int  f, fe, fe_new, ph;
        bit  at_end, boundary;
        f        = int'(bus.factor[i*W +: W]);
        fe       = (m_fa[i] < 1) ? 1 : m_fa[i];
        at_end   = (m_cnt[i] == fe - 1);
        boundary = !bus.en[i] || bus.sync || at_end;
        m_ce[i]  = bus.en[i] && !bus.sync && at_end;
        if (boundary) begin
          if (bus.load[i])   m_fa[i] = f;
          else if (m_pend[i]) m_fa[i] = m_fs[i];
          m_pend[i] = 1'b0;
        end else if (bus.load[i]) begin
          m_fs[i]   = f;
          m_pend[i] = 1'b1;
        end
        fe_new = (m_fa[i] < 1) ? 1 : m_fa[i];
        ph = 0;
`ifdef CE_GEN_MULTI_PHASE_EN
        ph = int'(bus.phase[i*W +: W]);
        if (ph > fe_new - 1) ph = fe_new - 1;
`endif
        if (!bus.en[i])    m_cnt[i] = 0;
        else if (bus.sync) m_cnt[i] = ph;
        else if (at_end)   m_cnt[i] = 0;
        else               m_cnt[i] = m_cnt[i] + 1;
      end
    end
  end

  // Cycle-by-cycle compare of the DUT outputs against the model.
  always @(negedge clk) begin
    if (run_cmp && !rst) begin
      total++;
      if ({bus.ce, bus.pending} !== {m_ce, m_pend}) begin
        bad++;
        $display("FAIL model_cmp t=%0t: ce/pending got %b/%b expected %b/%b",
                 $time, bus.ce, bus.pending, m_ce, m_pend);
      end
    end
  end

  task automatic chk(input string nm, input logic [CH-1:0] act,
                     input logic [CH-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s t=%0t: got %b expected %b", nm, $time, act, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  logic [CH-1:0] exp_a [1:6];

  initial begin
    exp_a[1] = 4'b1001; exp_a[2] = 4'b1011; exp_a[3] = 4'b1101;
    exp_a[4] = 4'b1011; exp_a[5] = 4'b1001; exp_a[6] = 4'b1111;

    rst = 1'b1;
    bus.en = '0; bus.load = '0; bus.sync = 1'b0; bus.factor = '0;
`ifdef CE_GEN_MULTI_PHASE_EN
    bus.phase = '0;
`endif
    #3;
    chk("reset_ce", bus.ce, 4'b0000);
    chk("reset_pending", bus.pending, 4'b0000);
    step(); step();
    rst = 1'b0;
    run_cmp = 1'b1;

    // Factors {1,2,3,0} loaded while disabled, then all channels enabled.
    bus.factor = {16'd0, 16'd3, 16'd2, 16'd1};
    bus.load = 4'b1111;
    step();
    bus.load = '0; bus.en = 4'b1111;
    for (int k = 1; k <= 6; k++) begin
      step();
      chk("div_pattern", bus.ce, exp_a[k]);
    end

    // Ch0 at F=5, reload to 2 mid-period.
    bus.en = '0; bus.factor = {16'd0, 16'd0, 16'd0, 16'd5}; bus.load = 4'b0001;
    step();
    bus.load = '0; bus.en = 4'b0001;
    step();
    bus.factor = {16'd0, 16'd0, 16'd0, 16'd2}; bus.load = 4'b0001;
    step();
    bus.load = '0;
    chk("shadow_pending", bus.pending, 4'b0001);
    step(); chk("old_period_3", bus.ce, 4'b0000);
    step(); chk("old_period_4", bus.ce, 4'b0000);
    step(); chk("old_period_end", bus.ce, 4'b0001);
    chk("pending_cleared", bus.pending, 4'b0000);
    step(); chk("new_period_1", bus.ce, 4'b0000);
    step(); chk("new_period_end", bus.ce, 4'b0001);

    // Load of 4 coincident with the wrap edge (ch0 now F=2, cnt=0).
    step();
    bus.factor = {16'd0, 16'd0, 16'd0, 16'd4}; bus.load = 4'b0001;
    step();
    bus.load = '0;
    chk("wrap_load_ce", bus.ce, 4'b0001);
    chk("wrap_load_pending", bus.pending, 4'b0000);
    for (int j = 1; j <= 4; j++) begin
      step();
      chk("wrap_load_period", bus.ce, (j == 4) ? 4'b0001 : 4'b0000);
    end

    // Sync with ch1 at F=4, cnt=2; ch2 disabled.
    bus.en = '0; bus.factor = {16'd0, 16'd0, 16'd4, 16'd0}; bus.load = 4'b0010;
    step();
    bus.load = '0; bus.en = 4'b0011;
    step(); step();
    bus.sync = 1'b1;
    step();
    bus.sync = 1'b0;
    chk("sync_drop", bus.ce & 4'b0110, 4'b0000);
    for (int j = 1; j <= 4; j++) begin
      step();
      chk("sync_restart", bus.ce & 4'b0110, (j == 4) ? 4'b0010 : 4'b0000);
    end

    // Asynchronous reset mid-period with a pending update outstanding.
    bus.en = '0; bus.factor = {16'd6, 16'd6, 16'd6, 16'd1}; bus.load = 4'b1111;
    step();
    bus.load = '0; bus.en = 4'b1111;
    step(); step();
    bus.factor = {16'd6, 16'd6, 16'd3, 16'd1}; bus.load = 4'b0010;
    step();
    bus.load = '0;
    chk("pre_rst_pending", bus.pending, 4'b0010);
    chk("pre_rst_ce", bus.ce, 4'b0001);
    #3 rst = 1'b1;
    #1;
    chk("async_rst_ce", bus.ce, 4'b0000);
    chk("async_rst_pending", bus.pending, 4'b0000);
    step();
    rst = 1'b0;
    step(); chk("post_rst_ce_1", bus.ce, 4'b1111);
    step(); chk("post_rst_ce_2", bus.ce, 4'b1111);

`ifdef CE_GEN_MULTI_PHASE_EN
    // Phase preload on sync: phase 3 and phase 9 (clamped) behave alike.
    for (int p = 0; p < 2; p++) begin
      bus.en = '0; bus.factor = {16'd0, 16'd0, 16'd0, 16'd4}; bus.load = 4'b0001;
      step();
      bus.load = '0; bus.en = 4'b0001; bus.sync = 1'b1;
      bus.phase = {16'd0, 16'd0, 16'd0, (p == 0) ? 16'd3 : 16'd9};
      step();
      bus.sync = 1'b0; bus.phase = '0;
      step(); chk("phase_first", bus.ce, 4'b0001);
      for (int j = 1; j <= 4; j++) begin
        step();
        chk("phase_period", bus.ce, (j == 4) ? 4'b0001 : 4'b0000);
      end
    end
`endif

    // Randomized run against the model.
    for (int n = 0; n < 3000; n++) begin
      for (int i = 0; i < CH; i++) begin
        bus.en[i]   = ($urandom_range(0, 15) != 0);
        bus.load[i] = ($urandom_range(0, 7) == 0);
        bus.factor[i*W +: W] = W'($urandom_range(0, 7));
`ifdef CE_GEN_MULTI_PHASE_EN
        bus.phase[i*W +: W] = W'($urandom_range(0, 9));
`endif
      end
      bus.sync = ($urandom_range(0, 24) == 0);
      step();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
